// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game-state and score-tracker types and constants
//                for the penalty shootout game.
//  Revision    : 1.0 - initial release with shootout score FSM type
// ============================================================================
package game_pkg;

  // Top-level game state driven by the game-state FSM.
  typedef enum logic [1:0] {
    TITLE   = 2'd0,
    SHOOTER = 2'd1,
    KEEPER  = 2'd2,
    RESULT  = 2'd3
  } g_state;

  // Score tracker phase.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REGULAR = 2'd1,
    SUDDEN  = 2'd2,
    DONE    = 2'd3
  } score_fsm_t;

  // Regulation kicks per side used by the shipping game.
  localparam int MATCH_ROUNDS = 5;

endpackage
`default_nettype wire

// File: rtl/score_decide.sv
`default_nettype none
// ============================================================================
//  Module      : score_decide
//  Description : Combinational match-decision logic. Given post-update scores
//                and kick counts plus the current phase, reports whether the
//                match is decided and who won. Early-decision comparators are
//                only built when SCORE_EARLY_END_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_decide #(
  parameter int ROUNDS  = 5,
  parameter int SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] score_player,
  input  logic [SCORE_W-1:0] score_enemy,
  input  logic [SCORE_W-1:0] kicks_player,
  input  logic [SCORE_W-1:0] kicks_enemy,
  input  logic               sudden,
  output logic               decided,
  output logic               winner
);

  // One extra bit so score + remaining kicks can never overflow.
  localparam int                 c_ext_w  = SCORE_W + 1;
  localparam logic [c_ext_w-1:0] c_rounds = c_ext_w'(ROUNDS);

  logic [c_ext_w-1:0] w_sp;
  logic [c_ext_w-1:0] w_se;
  logic [c_ext_w-1:0] w_kp;
  logic [c_ext_w-1:0] w_ke;
  logic               w_reg_full;
  logic               w_early_p;
  logic               w_early_e;

  assign w_sp = {1'b0, score_player};
  assign w_se = {1'b0, score_enemy};
  assign w_kp = {1'b0, kicks_player};
  assign w_ke = {1'b0, kicks_enemy};

  // Both sides have used up their regulation kicks.
  assign w_reg_full = (w_kp >= c_rounds) && (w_ke >= c_rounds);

`ifdef SCORE_EARLY_END_EN
  logic [c_ext_w-1:0] w_rem_p;
  logic [c_ext_w-1:0] w_rem_e;

  // Remaining regulation kicks, clamped at zero.
  assign w_rem_p = (w_kp >= c_rounds) ? '0 : (c_rounds - w_kp);
  assign w_rem_e = (w_ke >= c_rounds) ? '0 : (c_rounds - w_ke);

  // A side wins early when the other cannot catch up even scoring every kick.
  assign w_early_p = w_sp > (w_se + w_rem_e);
  assign w_early_e = w_se > (w_sp + w_rem_p);
`else
  assign w_early_p = 1'b0;
  assign w_early_e = 1'b0;
`endif

  // Decision priority: sudden-death round compare, then early win, then full regulation.
  always_comb begin
    decided = 1'b0;
    winner  = 1'b0;
    if (sudden) begin
      if ((w_kp == w_ke) && (w_sp != w_se)) begin
        decided = 1'b1;
        winner  = (w_sp > w_se);
      end
    end else if (w_early_p) begin
      decided = 1'b1;
      winner  = 1'b1;
    end else if (w_early_e) begin
      decided = 1'b1;
      winner  = 1'b0;
    end else if (w_reg_full && (w_sp != w_se)) begin
      decided = 1'b1;
      winner  = (w_sp > w_se);
    end
  end

endmodule
`default_nettype wire

// File: rtl/penalty_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : penalty_score_tracker
//  Description : Shootout score tracker. Counts goals and kicks per side over
//                ROUNDS regulation rounds, ends the match once decided and
//                runs sudden death after a regulation tie. Optional early
//                decision is enabled with SCORE_EARLY_END_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module penalty_score_tracker
  import game_pkg::*;
#(
  parameter int ROUNDS  = MATCH_ROUNDS,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  g_state             game_state,
  input  logic               round_done,
  input  logic               is_scored,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_enemy,
  output logic [SCORE_W-1:0] kicks_player,
  output logic [SCORE_W-1:0] kicks_enemy,
  output logic               sudden_death,
  output logic               match_end,
  output logic               match_result
);

  localparam logic [SCORE_W-1:0] c_max_cnt = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] c_rounds  = SCORE_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] c_one     = SCORE_W'(1);

  score_fsm_t         r_state;
  logic [SCORE_W-1:0] r_score_p;
  logic [SCORE_W-1:0] r_score_e;
  logic [SCORE_W-1:0] r_kicks_p;
  logic [SCORE_W-1:0] r_kicks_e;
  logic               r_sudden;
  logic               r_end;
  logic               r_result;

  logic               w_legal;
  logic               w_kick;
  logic               w_kick_p;
  logic               w_kick_e;
  logic [SCORE_W-1:0] w_score_p_n;
  logic [SCORE_W-1:0] w_score_e_n;
  logic [SCORE_W-1:0] w_kicks_p_n;
  logic [SCORE_W-1:0] w_kicks_e_n;
  logic               w_decided;
  logic               w_winner;
  logic               w_to_sudden;

  // Only SHOOTER and KEEPER are in-match states; anything else aborts.
  assign w_legal  = (game_state == SHOOTER) || (game_state == KEEPER);
  // Kicks are ignored once the match is decided.
  assign w_kick   = round_done && w_legal && (r_state != DONE);
  assign w_kick_p = w_kick && (game_state == SHOOTER);
  assign w_kick_e = w_kick && (game_state == KEEPER);

  // Post-update counters, saturating at all-ones.
  assign w_kicks_p_n = (w_kick_p && (r_kicks_p != c_max_cnt)) ? (r_kicks_p + c_one) : r_kicks_p;
  assign w_kicks_e_n = (w_kick_e && (r_kicks_e != c_max_cnt)) ? (r_kicks_e + c_one) : r_kicks_e;
  assign w_score_p_n = (w_kick_p && is_scored && (r_score_p != c_max_cnt)) ? (r_score_p + c_one) : r_score_p;
  assign w_score_e_n = (w_kick_e && is_scored && (r_score_e != c_max_cnt)) ? (r_score_e + c_one) : r_score_e;

  score_decide #(
    .ROUNDS  (ROUNDS),
    .SCORE_W (SCORE_W)
  ) u_score_decide (
    .score_player (w_score_p_n),
    .score_enemy  (w_score_e_n),
    .kicks_player (w_kicks_p_n),
    .kicks_enemy  (w_kicks_e_n),
    .sudden       (r_state == SUDDEN),
    .decided      (w_decided),
    .winner       (w_winner)
  );

  // Regulation exhausted with level scores hands over to sudden death.
  assign w_to_sudden = (r_state != SUDDEN) && !w_decided &&
                       (w_kicks_p_n >= c_rounds) && (w_kicks_e_n >= c_rounds);

  // Match FSM with registered counters and flags; reset and abort both clear everything.
  always_ff @(posedge clk) begin
    if (rst || !w_legal) begin
      r_state   <= IDLE;
      r_score_p <= '0;
      r_score_e <= '0;
      r_kicks_p <= '0;
      r_kicks_e <= '0;
      r_sudden  <= 1'b0;
      r_end     <= 1'b0;
      r_result  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, REGULAR, SUDDEN: begin
          r_score_p <= w_score_p_n;
          r_score_e <= w_score_e_n;
          r_kicks_p <= w_kicks_p_n;
          r_kicks_e <= w_kicks_e_n;
          if (w_decided) begin
            r_state  <= DONE;
            r_end    <= 1'b1;
            r_result <= w_winner;
            r_sudden <= 1'b0;
          end else if (w_to_sudden) begin
            r_state  <= SUDDEN;
            r_sudden <= 1'b1;
          end else if (r_state == IDLE) begin
            r_state  <= REGULAR;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign score_player = r_score_p;
  assign score_enemy  = r_score_e;
  assign kicks_player = r_kicks_p;
  assign kicks_enemy  = r_kicks_e;
  assign sudden_death = r_sudden;
  assign match_end    = r_end;
  assign match_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_penalty_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_penalty_score_tracker
//  Description : Scoreboard bench for penalty_score_tracker (ROUNDS=5,
//                SCORE_W=4). Driver pushes the expected post-edge outputs for
//                every driven cycle; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_penalty_score_tracker;
  import game_pkg::*;

`ifdef SCORE_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [3:0] sp;
    logic [3:0] se;
    logic [3:0] kp;
    logic [3:0] ke;
    logic       sd;
    logic       me;
    logic       mr;
  } exp_t;

  logic       clk;
  logic       rst;
  g_state     game_state;
  logic       round_done;
  logic       is_scored;
  logic [3:0] score_player;
  logic [3:0] score_enemy;
  logic [3:0] kicks_player;
  logic [3:0] kicks_enemy;
  logic       sudden_death;
  logic       match_end;
  logic       match_result;

  exp_t q[$];
  logic issue;
  int   n_pass;
  int   n_total;

  penalty_score_tracker #(
    .ROUNDS  (5),
    .SCORE_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .round_done   (round_done),
    .is_scored    (is_scored),
    .score_player (score_player),
    .score_enemy  (score_enemy),
    .kicks_player (kicks_player),
    .kicks_enemy  (kicks_enemy),
    .sudden_death (sudden_death),
    .match_end    (match_end),
    .match_result (match_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input g_state gs, input logic rd, input logic sc, input logic rs,
                      input int sp, input int se, input int kp, input int ke,
                      input logic sd, input logic me, input logic mr);
    exp_t e;
    @(negedge clk);
    game_state = gs;
    round_done = rd;
    is_scored  = sc;
    rst        = rs;
    e.sp = 4'(sp);
    e.se = 4'(se);
    e.kp = 4'(kp);
    e.ke = 4'(ke);
    e.sd = sd;
    e.me = me;
    e.mr = mr;
    q.push_back(e);
    issue = 1'b1;
  endtask

  task automatic kick(input g_state gs, input logic sc,
                      input int sp, input int se, input int kp, input int ke,
                      input logic sd, input logic me, input logic mr);
    step(gs, 1'b1, sc, 1'b0, sp, se, kp, ke, sd, me, mr);
  endtask

  task automatic abort_chk();
    step(TITLE, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT outputs 1 time unit after every edge that followed a driven cycle.
  initial begin
    exp_t e;
    logic iss;
    forever begin
      @(posedge clk);
      iss = issue;
      #1;
      if (iss) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
        end else begin
          e = q.pop_front();
          chk("score_player", int'(score_player), int'(e.sp));
          chk("score_enemy",  int'(score_enemy),  int'(e.se));
          chk("kicks_player", int'(kicks_player), int'(e.kp));
          chk("kicks_enemy",  int'(kicks_enemy),  int'(e.ke));
          chk("sudden_death", int'(sudden_death), int'(e.sd));
          chk("match_end",    int'(match_end),    int'(e.me));
          if (e.me) chk("match_result", int'(match_result), int'(e.mr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fkp;
    int last;
    n_pass     = 0;
    n_total    = 0;
    issue      = 1'b0;
    rst        = 1'b1;
    game_state = TITLE;
    round_done = 1'b0;
    is_scored  = 1'b0;

    // Reset held two cycles, then one idle cycle.
    step(TITLE, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(TITLE, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    abort_chk();

    // Player scores three, enemy misses three: 3-0.
    kick(SHOOTER, 1'b1, 1, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    kick(KEEPER,  1'b0, 1, 0, 1, 1, 1'b0, 1'b0, 1'b0);
    kick(SHOOTER, 1'b1, 2, 0, 2, 1, 1'b0, 1'b0, 1'b0);
    kick(KEEPER,  1'b0, 2, 0, 2, 2, 1'b0, 1'b0, 1'b0);
    kick(SHOOTER, 1'b1, 3, 0, 3, 2, 1'b0, 1'b0, 1'b0);
    kick(KEEPER,  1'b0, 3, 0, 3, 3, 1'b0, EARLY, EARLY);
    if (!EARLY) begin
      kick(SHOOTER, 1'b0, 3, 0, 4, 3, 1'b0, 1'b0, 1'b0);
      kick(KEEPER,  1'b0, 3, 0, 4, 4, 1'b0, 1'b0, 1'b0);
      kick(SHOOTER, 1'b0, 3, 0, 5, 4, 1'b0, 1'b0, 1'b0);
      kick(KEEPER,  1'b0, 3, 0, 5, 5, 1'b0, 1'b1, 1'b1);
    end
    fkp = EARLY ? 3 : 5;
    // Kicks while decided are ignored.
    kick(SHOOTER, 1'b1, 3, 0, fkp, fkp, 1'b0, 1'b1, 1'b1);
    kick(KEEPER,  1'b1, 3, 0, fkp, fkp, 1'b0, 1'b1, 1'b1);
    step(KEEPER, 1'b0, 1'b0, 1'b0, 3, 0, fkp, fkp, 1'b0, 1'b1, 1'b1);
    abort_chk();

    // Alternating goals to 5-5, then sudden death 6-5.
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) kick(SHOOTER, 1'b1, (i + 1) / 2, (i - 1) / 2, (i + 1) / 2, (i - 1) / 2, 1'b0, 1'b0, 1'b0);
      else            kick(KEEPER,  1'b1, i / 2, i / 2, i / 2, i / 2, (i == 10), 1'b0, 1'b0);
    end
    kick(SHOOTER, 1'b1, 6, 5, 6, 5, 1'b1, 1'b0, 1'b0);
    kick(KEEPER,  1'b0, 6, 5, 6, 6, 1'b0, 1'b1, 1'b1);
    abort_chk();

    // Enemy wins: player always misses, enemy always scores.
    last = EARLY ? 6 : 10;
    for (int i = 1; i <= last; i++) begin
      if (i % 2 == 1) kick(SHOOTER, 1'b0, 0, (i - 1) / 2, (i + 1) / 2, (i - 1) / 2, 1'b0, 1'b0, 1'b0);
      else            kick(KEEPER,  1'b1, 0, i / 2, i / 2, i / 2, 1'b0, (i == last), 1'b0);
    end
    abort_chk();

    // Mid-match abort at 2-1; a kick during the abort cycle is ignored.
    kick(SHOOTER, 1'b1, 1, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    kick(KEEPER,  1'b1, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0);
    kick(SHOOTER, 1'b1, 2, 1, 2, 1, 1'b0, 1'b0, 1'b0);
    step(TITLE, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Match restarts from IDLE and counts the entry-cycle kick.
    kick(KEEPER, 1'b1, 0, 1, 0, 1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    issue      = 1'b0;
    round_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/penalty_score_tracker.md
# penalty_score_tracker

Parametrised shootout score tracker for the penalty game. It counts goals and kicks for the player and the enemy across a configurable number of regulation rounds. It declares the winner early once the result is mathematically decided, and runs sudden death after a tie. It sits between the game-state FSM and the result/HUD logic and generalises the fixed first-to-5, keeper-only scoring.

## Interface
Parameters:
- ROUNDS, default 5: regulation kicks per side.
- SCORE_W, default 4: width of score and kick counters; must be ≥ $clog2(ROUNDS+1)+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- game_state  in  g_state  current game state. SHOOTER means the player kicks; KEEPER means the enemy kicks.
- round_done  in  1  single-cycle pulse: a kick has resolved.
- is_scored  in  1  valid with round_done: 1 = the kick was a goal for the kicking side.
- score_player  out  SCORE_W  player goals.
- score_enemy  out  SCORE_W  enemy goals.
- kicks_player  out  SCORE_W  player kicks taken.
- kicks_enemy  out  SCORE_W  enemy kicks taken.
- sudden_death  out  1  sudden-death phase active.
- match_end  out  1  match decided; held.
- match_result  out  1  1 = player won, 0 = enemy won. Meaningful only while match_end = 1.

## Operation
- FSM states: IDLE, REGULAR, SUDDEN, DONE. Every output is registered.
- IDLE:
  - Counters 0, flags 0.
  - game_state ∈ {SHOOTER, KEEPER} → REGULAR, same cycle as entry.
  - A round_done in that same cycle is counted.
- Kick update, on round_done in REGULAR or SUDDEN:
  - SHOOTER: kicks_player +1; score_player +1 if is_scored.
  - KEEPER: kicks_enemy +1; score_enemy +1 if is_scored.
- Decision uses post-update values. Let remP = ROUNDS − kicks_player and remE = ROUNDS − kicks_enemy.
- REGULAR, early decision:
  - score_player > score_enemy + remE → DONE, result 1.
  - score_enemy > score_player + remP → DONE, result 0.
- REGULAR, both kick counts = ROUNDS:
  - Scores differ → DONE with the leader as winner.
  - Tie → SUDDEN; sudden_death = 1.
- SUDDEN:
  - Evaluate only when kicks_player == kicks_enemy.
  - Scores differ → DONE.
  - Otherwise stay in SUDDEN.
- DONE:
  - match_end = 1 and match_result are held.
  - round_done is ignored; counters are frozen.
- game_state outside {SHOOTER, KEEPER}, in any state → IDLE with all outputs cleared next cycle. This is the mid-match abort.
- Counters saturate at 2^SCORE_W − 1 and never wrap. On saturation in SUDDEN, the match stays in SUDDEN until a side leads.
- round_done with no legal game_state is ignored.

## Timing
- Latency from round_done (cycle N) to updated counters and match_end/sudden_death: 1 cycle (visible at N+1).
- No back-pressure. Pulses on consecutive cycles are each counted.
- rst overrides everything: all outputs 0, state IDLE at the next edge.

## Configuration
- SCORE_EARLY_END_EN:
  - Defined: early decision in REGULAR as above.
  - Undefined: REGULAR ends only when both kick counts = ROUNDS. Winner/tie evaluation is identical; the early-decision comparators are not built.

## Structure
- game_pkg holds:
  - g_state (existing).
  - New typedef score_fsm_t {IDLE, REGULAR, SUDDEN, DONE}.
  - Constant MATCH_ROUNDS = 5, used as the top-level ROUNDS override.
- One sub-module, score_decide: purely combinational. Takes post-update scores, kick counts and phase. Outputs decided and winner. Parametrised by ROUNDS and SCORE_W; holds the early-end comparators under the macro.

## Test plan
All scenarios use ROUNDS = 5, SCORE_W = 4, with SHOOTER/KEEPER alternating and the player kicking first.
- rst held 2 cycles → all outputs 0, sudden_death 0, match_end 0.
- Macro defined; P goal, E miss ×3 → after the 6th round_done: score 3-0, kicks 3/3, match_end 1, match_result 1.
- Macro undefined; same sequence then all misses → match_end stays 0 until the 10th kick, then 1 with result 1 (3-0).
- Alternating goals for 10 kicks (5-5) → sudden_death 1, match_end 0; then P goal, E miss → match_end 1, result 1, score 6-5.
- game_state → non-game state mid-match at 2-1 → next cycle all counters 0, state IDLE, match_end 0.
- round_done pulses while DONE → scores and kick counts unchanged; match_end and match_result held.
